// File: rtl/uart_inst_loader_pkg.sv
// Shared definitions for the UART instruction loader: FSM encoding,
// frame-format constants and small helpers.
package uart_inst_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } uart_inst_loader_state_t;

  // Frame header byte used when the top-level parameter is left at default
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Word count travels in a single byte, so a frame holds at most 255 words
  localparam int MAX_WORDS = 255;
  localparam int CNT_W     = $clog2(MAX_WORDS + 1);

  // Idle cycles tolerated between bytes of a frame before it is abandoned
  localparam int TIMEOUT_DEFAULT = 100000;

  // True in the states where a frame is being received and the gap timer runs
  function automatic logic in_frame(input uart_inst_loader_state_t s);
    return (s == ST_COUNT) || (s == ST_HI) || (s == ST_LO) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/loader_timeout_cnt.sv
// Inter-byte gap counter. Counts enabled cycles since the last clear and
// flags expiry on the cycle where the count has reached TIMEOUT-1 and no
// clear is present, so the owner can abort on that same edge.
module loader_timeout_cnt
  import uart_inst_loader_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int GW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [GW-1:0] LAST = GW'(TIMEOUT - 1);

  logic [GW-1:0] gap;

  assign expire = enable && !clear && (gap == LAST);

  // Gap register: cleared by a byte (or outside a frame), else counts up
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      gap <= '0;
    end else if (enable && !expire) begin
      gap <= gap + GW'(1);
    end
  end

endmodule

// File: rtl/uart_inst_loader.sv
// Boot/reload controller: receives a framed instruction image over the UART,
// writes it into instruction memory as 16-bit words, keeps the CPU stalled
// while loading and pulses a PC reset once a checksum-verified image is in.
//
// Handshake: rx_valid is a single-cycle strobe qualifying rx_data; there is
// no backpressure, every strobe is consumed in the cycle it appears. rx_err
// is a single-cycle strobe that aborts any frame in progress and wins over a
// same-cycle rx_valid. All outputs are registered; their values are decided
// from the next FSM state so pulses line up with the state they belong to.
module uart_inst_loader
  import uart_inst_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter logic [15:0] BASE_ADDR      = 16'h0000,
  parameter int          TIMEOUT        = TIMEOUT_DEFAULT,
  parameter bit          STALL_AT_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_err,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic        cpu_stall,
  output logic        pc_rst,
  output logic        load_done,
  output logic        load_err,
  output logic        busy
);

  uart_inst_loader_state_t state, next_state;

  logic [7:0]       csum;
  logic [7:0]       hi_reg;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] idx;

  logic frame_active;
  logic byte_ok;
  logic last_word;
  logic gap_expire;

  logic        imem_we_d;
  logic [15:0] imem_addr_d;
  logic [15:0] imem_wdata_d;
  logic        cpu_stall_d;
  logic        pc_rst_d;
  logic        load_done_d;
  logic        load_err_d;
  logic        busy_d;

  assign frame_active = in_frame(state);
  assign byte_ok      = rx_valid && !rx_err;
  assign last_word    = (idx == word_cnt - CNT_W'(1));

  loader_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (!frame_active || rx_valid),
    .enable (frame_active),
    .expire (gap_expire)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: line error, then timeout, then the per-byte protocol
  always_comb begin
    next_state = state;
    if (frame_active && rx_err) begin
      next_state = ST_ERR;
    end else if (frame_active && !rx_valid && gap_expire) begin
      next_state = ST_ERR;
    end else begin
      case (state)
        ST_IDLE:  if (rx_valid && rx_data == SYNC_BYTE) next_state = ST_COUNT;
        ST_COUNT: if (rx_valid) next_state = (rx_data == 8'd0) ? ST_ERR : ST_HI;
        ST_HI:    if (rx_valid) next_state = ST_LO;
        ST_LO:    if (rx_valid) next_state = last_word ? ST_CSUM : ST_HI;
        ST_CSUM:  if (rx_valid) next_state = (rx_data == csum) ? ST_DONE : ST_ERR;
        ST_DONE:  next_state = ST_IDLE;
        ST_ERR:   next_state = ST_IDLE;
        default:  next_state = ST_IDLE;
      endcase
    end
  end

  // Frame datapath: running checksum, high byte holding, word counters
  always_ff @(posedge clk) begin
    if (reset) begin
      csum     <= '0;
      hi_reg   <= '0;
      word_cnt <= '0;
      idx      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_valid && rx_data == SYNC_BYTE) csum <= '0;
        end
        ST_COUNT: begin
          if (byte_ok) begin
            word_cnt <= rx_data;
            idx      <= '0;
            csum     <= csum ^ rx_data;
          end
        end
        ST_HI: begin
          if (byte_ok) begin
            hi_reg <= rx_data;
            csum   <= csum ^ rx_data;
          end
        end
        ST_LO: begin
          if (byte_ok) begin
            csum <= csum ^ rx_data;
            if (!last_word) idx <= idx + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode: values each output register takes on the next edge
  always_comb begin
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    cpu_stall_d  = cpu_stall;
    pc_rst_d     = 1'b0;
    load_done_d  = 1'b0;
    load_err_d   = 1'b0;
    busy_d       = (next_state != ST_IDLE);

    if (state == ST_IDLE && next_state == ST_COUNT) cpu_stall_d = 1'b1;

    // Words go to memory as soon as complete, ahead of the checksum; the
    // stall stays up until the checksum passes, so a bad image never runs.
    if (state == ST_LO && byte_ok) begin
      imem_we_d    = 1'b1;
      imem_addr_d  = BASE_ADDR + 16'(idx);
      imem_wdata_d = {hi_reg, rx_data};
    end

    if (next_state == ST_DONE) begin
      pc_rst_d    = 1'b1;
      load_done_d = 1'b1;
      cpu_stall_d = 1'b0;
    end

    if (next_state == ST_ERR) load_err_d = 1'b1;
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_stall  <= STALL_AT_RESET;
      pc_rst     <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      imem_we    <= imem_we_d;
      imem_addr  <= imem_addr_d;
      imem_wdata <= imem_wdata_d;
      cpu_stall  <= cpu_stall_d;
      pc_rst     <= pc_rst_d;
      load_done  <= load_done_d;
      load_err   <= load_err_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_inst_loader.sv
// Testbench for uart_inst_loader: table of whole frames, hand-written timing
// sequences, and random frames checked against a frame-level reference model.
module tb_uart_inst_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_err;

  logic        imem_we, cpu_stall, pc_rst, load_done, load_err, busy;
  logic [15:0] imem_addr, imem_wdata;

  logic        w_imem_we, w_cpu_stall, w_pc_rst, w_load_done, w_load_err, w_busy;
  logic [15:0] w_imem_addr, w_imem_wdata;

  uart_inst_loader #(
    .BASE_ADDR (16'h0000),
    .TIMEOUT   (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_err     (rx_err),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_stall  (cpu_stall),
    .pc_rst     (pc_rst),
    .load_done  (load_done),
    .load_err   (load_err),
    .busy       (busy)
  );

  // Second instance sees the same byte stream; used for address wrap and
  // the stall-at-reset option.
  uart_inst_loader #(
    .BASE_ADDR      (16'hFFFF),
    .TIMEOUT        (16),
    .STALL_AT_RESET (1'b1)
  ) dut_w (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_err     (rx_err),
    .imem_we    (w_imem_we),
    .imem_addr  (w_imem_addr),
    .imem_wdata (w_imem_wdata),
    .cpu_stall  (w_cpu_stall),
    .pc_rst     (w_pc_rst),
    .load_done  (w_load_done),
    .load_err   (w_load_err),
    .busy       (w_busy)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] got_w_q[$];
  int          n_done;
  int          n_err;
  bit          exp_stall;

  logic [7:0]  frm_q[$];
  int          err_at;
  int          cut_at;
  bit          exp_done;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: collects writes and pulses, checks pc_rst/load_done pairing
  always @(negedge clk) begin
    if (imem_we)   got_q.push_back({imem_addr, imem_wdata});
    if (w_imem_we) got_w_q.push_back({w_imem_addr, w_imem_wdata});
    if (load_done) n_done++;
    if (load_err)  n_err++;
    if (pc_rst || load_done) begin
      check("pc_rst_eq_load_done", 32'(pc_rst), 32'(load_done));
      check("stall_low_at_done", 32'(cpu_stall), 32'd0);
    end
  end

  task automatic clear_mon();
    got_q.delete();
    got_w_q.delete();
    n_done = 0;
    n_err  = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit err);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    rx_err   = err;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  // Sends frm_q, honouring err_at (rx_err on that byte, stop) and cut_at
  // (stop before that byte and stay silent past the timeout).
  task automatic send_frame(input bit rnd_gaps);
    for (int i = 0; i < frm_q.size(); i++) begin
      if (i == cut_at) break;
      if (rnd_gaps) idle($urandom_range(0, 4));
      send_byte(frm_q[i], i == err_at);
      if (i == err_at) break;
    end
    if (cut_at >= 0) idle(20);
    idle(3);
  endtask

  // Reference model at frame level: which words land and how it ends
  task automatic model_frame();
    int words;
    int p;
    logic [7:0] x;
    exp_q.delete();
    if (err_at >= 0 || cut_at >= 0) begin
      p = (err_at >= 0) ? err_at : cut_at;
      words = (p >= 2) ? (p - 2) / 2 : 0;
      exp_done = 1'b0;
    end else begin
      words = int'(frm_q[1]);
      x = 8'h00;
      for (int i = 1; i < frm_q.size() - 1; i++) x ^= frm_q[i];
      exp_done = (x == frm_q[frm_q.size() - 1]);
    end
    for (int k = 0; k < words; k++)
      exp_q.push_back({16'(k), frm_q[2 + 2 * k], frm_q[3 + 2 * k]});
  endtask

  task automatic compare_frame(input string tag);
    check({tag, " nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s write%0d", tag, i), got_q[i], exp_q[i]);
    exp_stall = !exp_done;
    check({tag, " load_done"}, 32'(n_done), exp_done ? 32'd1 : 32'd0);
    check({tag, " load_err"}, 32'(n_err), exp_done ? 32'd0 : 32'd1);
    check({tag, " cpu_stall"}, 32'(cpu_stall), 32'(exp_stall));
    check({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          len;
    logic [7:0]  bytes [10];
    int          nwr;
    logic [31:0] wr [3];
    bit          done;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n;
    int mode;
    logic [7:0] cs;

    // Good 2-word frame: 02^12^34^AB^CD = 42
    tbl[0].len = 7;
    tbl[0].bytes = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42, 8'h00, 8'h00, 8'h00};
    tbl[0].nwr = 2;
    tbl[0].wr = '{32'h0000_1234, 32'h0001_ABCD, 32'h0};
    tbl[0].done = 1'b1;
    // Same frame, wrong checksum: both words still written
    tbl[1].len = 7;
    tbl[1].bytes = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41, 8'h00, 8'h00, 8'h00};
    tbl[1].nwr = 2;
    tbl[1].wr = '{32'h0000_1234, 32'h0001_ABCD, 32'h0};
    tbl[1].done = 1'b0;
    // Zero word count
    tbl[2].len = 2;
    tbl[2].bytes = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[2].nwr = 0;
    tbl[2].wr = '{32'h0, 32'h0, 32'h0};
    tbl[2].done = 1'b0;
    // Noise in idle then a 1-word frame: 01^BE^EF = 50
    tbl[3].len = 7;
    tbl[3].bytes = '{8'h55, 8'h66, 8'hA5, 8'h01, 8'hBE, 8'hEF, 8'h50, 8'h00, 8'h00, 8'h00};
    tbl[3].nwr = 1;
    tbl[3].wr = '{32'h0000_BEEF, 32'h0, 32'h0};
    tbl[3].done = 1'b1;
    // Sync byte value inside a frame is plain data: 01^A5^A5 = 01
    tbl[4].len = 5;
    tbl[4].bytes = '{8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[4].nwr = 1;
    tbl[4].wr = '{32'h0000_A5A5, 32'h0, 32'h0};
    tbl[4].done = 1'b1;
    // 3-word frame: 03^00^01^00^02^00^03 = 03
    tbl[5].len = 9;
    tbl[5].bytes = '{8'hA5, 8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h03, 8'h00};
    tbl[5].nwr = 3;
    tbl[5].wr = '{32'h0000_0001, 32'h0001_0002, 32'h0002_0003};
    tbl[5].done = 1'b1;

    // ---- reset ----
    reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_err = 1'b0;
    err_at = -1; cut_at = -1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst imem_we", 32'(imem_we), 32'd0);
    check("rst imem_addr", 32'(imem_addr), 32'd0);
    check("rst imem_wdata", 32'(imem_wdata), 32'd0);
    check("rst pc_rst", 32'(pc_rst), 32'd0);
    check("rst load_done", 32'(load_done), 32'd0);
    check("rst load_err", 32'(load_err), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst cpu_stall", 32'(cpu_stall), 32'd0);
    check("rst cpu_stall stall_at_reset", 32'(w_cpu_stall), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_stall = 1'b0;
    clear_mon();

    // ---- table-driven frames ----
    for (int v = 0; v < 6; v++) begin
      frm_q.delete();
      exp_q.delete();
      for (int i = 0; i < tbl[v].len; i++) frm_q.push_back(tbl[v].bytes[i]);
      for (int i = 0; i < tbl[v].nwr; i++) exp_q.push_back(tbl[v].wr[i]);
      exp_done = tbl[v].done;
      err_at = -1; cut_at = -1;
      clear_mon();
      send_frame(1'b0);
      compare_frame($sformatf("vec%0d", v));
    end

    // ---- write latency and done/pc_rst alignment: 01^12^34 = 27 ----
    clear_mon();
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
    @(negedge clk);
    check("lat imem_we", 32'(imem_we), 32'd1);
    check("lat imem_addr", 32'(imem_addr), 32'h0000);
    check("lat imem_wdata", 32'(imem_wdata), 32'h1234);
    @(negedge clk);
    check("lat imem_we one cycle", 32'(imem_we), 32'd0);
    send_byte(8'h27, 0);
    @(negedge clk);
    check("done pc_rst", 32'(pc_rst), 32'd1);
    check("done load_done", 32'(load_done), 32'd1);
    check("done cpu_stall", 32'(cpu_stall), 32'd0);
    check("done busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("done pc_rst one cycle", 32'(pc_rst), 32'd0);
    check("done busy after", 32'(busy), 32'd0);
    idle(2);
    exp_stall = 1'b0;

    // ---- zero count: error next cycle, then idle bytes ignored ----
    clear_mon();
    send_byte(8'hA5, 0); send_byte(8'h00, 0);
    @(negedge clk);
    check("n0 load_err", 32'(load_err), 32'd1);
    check("n0 imem_we", 32'(imem_we), 32'd0);
    send_byte(8'h55, 0);
    @(negedge clk);
    check("idle55 busy", 32'(busy), 32'd0);
    send_byte(8'h66, 0);
    @(negedge clk);
    check("idle66 busy", 32'(busy), 32'd0);
    idle(2);
    check("n0 errs", 32'(n_err), 32'd1);
    check("n0 cpu_stall", 32'(cpu_stall), 32'd1);
    exp_stall = 1'b1;

    // ---- timeout: error exactly 16 cycles after the last byte ----
    clear_mon();
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h12, 0);
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (load_err) break;
    end
    check("timeout cycles", 32'(cyc), 32'd16);
    idle(2);
    check("timeout writes", 32'(got_q.size()), 32'd0);

    // ---- rx_err together with the low byte: that word is not written ----
    clear_mon();
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'hAB, 0); send_byte(8'hCD, 1);
    @(negedge clk);
    check("rxerr load_err", 32'(load_err), 32'd1);
    check("rxerr imem_we", 32'(imem_we), 32'd0);
    idle(2);
    check("rxerr writes", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("rxerr write0", got_q[0], 32'h0000_1234);

    // ---- reset while waiting for a high byte ----
    clear_mon();
    send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
    send_byte(8'h33, 0); send_byte(8'h44, 0);
    @(negedge clk);
    check("pre-rst imem_addr", 32'(imem_addr), 32'h0001);
    check("pre-rst busy", 32'(busy), 32'd1);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    check("midrst imem_we", 32'(imem_we), 32'd0);
    check("midrst imem_addr", 32'(imem_addr), 32'd0);
    check("midrst imem_wdata", 32'(imem_wdata), 32'd0);
    check("midrst cpu_stall", 32'(cpu_stall), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst load_err", 32'(load_err), 32'd0);
    check("midrst pc_rst", 32'(pc_rst), 32'd0);
    check("midrst stall_at_reset", 32'(w_cpu_stall), 32'd1);
    clear_mon();
    send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h77, 0);
    idle(3);
    check("midrst tail busy", 32'(busy), 32'd0);
    check("midrst tail writes", 32'(got_q.size()), 32'd0);
    check("midrst tail pulses", 32'(n_done + n_err), 32'd0);
    exp_stall = 1'b0;

    // ---- address wrap on the FFFF-based instance ----
    clear_mon();
    frm_q = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    err_at = -1; cut_at = -1;
    send_frame(1'b0);
    check("wrap nwrites", 32'(got_w_q.size()), 32'd2);
    if (got_w_q.size() == 2) begin
      check("wrap write0", got_w_q[0], 32'hFFFF_1234);
      check("wrap write1", got_w_q[1], 32'h0000_ABCD);
    end
    check("wrap cpu_stall", 32'(w_cpu_stall), 32'd0);
    exp_stall = 1'b0;

    // ---- random frames against the frame-level model ----
    for (int f = 0; f < 40; f++) begin
      n    = $urandom_range(1, 6);
      mode = $urandom_range(0, 3);
      frm_q.delete();
      frm_q.push_back(8'hA5);
      frm_q.push_back(8'(n));
      for (int i = 0; i < 2 * n; i++) frm_q.push_back(8'($urandom_range(0, 255)));
      cs = 8'h00;
      for (int i = 1; i < frm_q.size(); i++) cs ^= frm_q[i];
      if (mode == 1) cs ^= 8'($urandom_range(1, 255));
      frm_q.push_back(cs);
      err_at = (mode == 2) ? int'($urandom_range(1, frm_q.size() - 1)) : -1;
      cut_at = (mode == 3) ? int'($urandom_range(1, frm_q.size() - 1)) : -1;
      model_frame();
      clear_mon();
      send_frame(1'b1);
      compare_frame($sformatf("rnd%0d", f));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
